// File: rtl/bfly_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bfly_sched : address/control scheduler for one 256-point butterfly pass,   |
// |              8 stages x 128 butterflies, write-back delayed by WB_LAT.     |
// | Option    : define BFLY_SCHED_HOLD_EN to add the hold (issue pause) port.  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module bfly_sched #(
   parameter int WB_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
`ifdef BFLY_SCHED_HOLD_EN
   input  logic       hold,
`endif
   output logic       busy,
   output logic       done,
   output logic       rd_en,
   output logic [7:0] rd_addr1,
   output logic [7:0] rd_addr2,
   output logic       wr_en,
   output logic [7:0] wr_addr1,
   output logic [7:0] wr_addr2,
   output logic [6:0] bf_i,
   output logic [8:0] bf_n,
   output logic [2:0] stage
);

   localparam logic [1:0] c_gap_last = 2'(WB_LAT - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_GAP   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic       en;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [6:0] bi;
      logic [8:0] bn;
   } wb_t;

   state_t     r_state, w_state_nxt;
   logic [6:0] r_j, w_j_nxt;
   logic [2:0] r_stage, w_stage_nxt;
   logic [1:0] r_cnt, w_cnt_nxt;
   logic       w_hold;
   logic       w_issue;

   logic [8:0] w_n;
   logic [7:0] w_h;
   logic [6:0] w_hmask;
   logic [6:0] w_i;
   logic [7:0] w_base;
   wb_t        w_rd;
   wb_t        r_pipe [WB_LAT];

`ifdef BFLY_SCHED_HOLD_EN
   assign w_hold = hold;
`else
   assign w_hold = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_j     <= '0;
         r_stage <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_j     <= w_j_nxt;
         r_stage <= w_stage_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // GAP and DRAIN both last exactly WB_LAT cycles, timed by r_cnt
   always_comb begin
      w_state_nxt = r_state;
      w_j_nxt     = r_j;
      w_stage_nxt = r_stage;
      w_cnt_nxt   = r_cnt;
      w_issue     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
               w_j_nxt     = '0;
               w_stage_nxt = '0;
               w_cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (!w_hold) begin
               w_issue = 1'b1;
               if (r_j == 7'd127) begin
                  w_j_nxt     = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = (r_stage == 3'd7) ? ST_DRAIN : ST_GAP;
               end else begin
                  w_j_nxt = r_j + 7'd1;
               end
            end
         end
         ST_GAP: begin
            busy = 1'b1;
            if (r_cnt == c_gap_last) begin
               w_state_nxt = ST_RUN;
               w_stage_nxt = r_stage + 3'd1;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 2'd1;
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (r_cnt == c_gap_last) begin
               w_state_nxt = ST_DONE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 2'd1;
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
            w_j_nxt     = '0;
            w_stage_nxt = '0;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Group base g*n equals (j with the low log2(h) bits cleared) * 2
   always_comb begin
      w_n     = 9'd256 >> r_stage;
      w_h     = 8'd128 >> r_stage;
      w_hmask = 7'(w_h - 8'd1);
      w_i     = r_j & w_hmask;
      w_base  = {r_j & ~w_hmask, 1'b0};
      w_rd    = '0;
      if (w_issue) begin
         w_rd.en = 1'b1;
         w_rd.a1 = w_base + {1'b0, w_i};
         w_rd.a2 = w_base + 8'(w_n - 9'd1 - {2'b0, w_i});
         w_rd.bi = w_i;
         w_rd.bn = w_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < WB_LAT; k++) r_pipe[k] <= '0;
      end else begin
         r_pipe[0] <= w_rd;
         for (int k = 1; k < WB_LAT; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end

   assign rd_en    = w_rd.en;
   assign rd_addr1 = w_rd.a1;
   assign rd_addr2 = w_rd.a2;
   assign stage    = r_stage;
   assign wr_en    = r_pipe[WB_LAT-1].en;
   assign wr_addr1 = r_pipe[WB_LAT-1].a1;
   assign wr_addr2 = r_pipe[WB_LAT-1].a2;
   assign bf_i     = r_pipe[WB_LAT-1].bi;
   assign bf_n     = r_pipe[WB_LAT-1].bn;

endmodule
`default_nettype wire

// File: tb/tb_bfly_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bfly_sched : two schedulers (WB_LAT 1 and 3) against a pass-level model |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_bfly_sched;

   localparam int NDUT = 2;
   localparam int LOGN = 1400;
   localparam longint FAR = 64'h7fff_ffff_ffff;
`ifdef BFLY_SCHED_HOLD_EN
   localparam bit HOLD_ON = 1'b1;
`else
   localparam bit HOLD_ON = 1'b0;
`endif

   typedef struct packed {
      logic       en;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [6:0] bi;
      logic [8:0] bn;
   } tup_t;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rd_en;
      logic [7:0] ra1;
      logic [7:0] ra2;
      logic [2:0] stage;
      tup_t       wr;
   } obs_t;

   typedef struct {
      int d; int k; bit rd; int a1; int a2; int st; bit done;
      bit wchk; bit wen; int wa1; int wa2; int wbn; int wbi;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic hold = 1'b0;

   logic       busy0, done0, rd_en0, wr_en0, busy1, done1, rd_en1, wr_en1;
   logic [7:0] ra1_0, ra2_0, wa1_0, wa2_0, ra1_1, ra2_1, wa1_1, wa2_1;
   logic [6:0] bi0, bi1;
   logic [8:0] bn0, bn1;
   logic [2:0] st0, st1;
   obs_t       o0, o1;

   always #5 clk = ~clk;

   bfly_sched #(.WB_LAT(1)) dut0 (
      .clk(clk), .rst(rst), .start(start),
`ifdef BFLY_SCHED_HOLD_EN
      .hold(hold),
`endif
      .busy(busy0), .done(done0), .rd_en(rd_en0),
      .rd_addr1(ra1_0), .rd_addr2(ra2_0), .wr_en(wr_en0),
      .wr_addr1(wa1_0), .wr_addr2(wa2_0), .bf_i(bi0), .bf_n(bn0), .stage(st0)
   );

   bfly_sched #(.WB_LAT(3)) dut1 (
      .clk(clk), .rst(rst), .start(start),
`ifdef BFLY_SCHED_HOLD_EN
      .hold(hold),
`endif
      .busy(busy1), .done(done1), .rd_en(rd_en1),
      .rd_addr1(ra1_1), .rd_addr2(ra2_1), .wr_en(wr_en1),
      .wr_addr1(wa1_1), .wr_addr2(wa2_1), .bf_i(bi1), .bf_n(bn1), .stage(st1)
   );

   assign o0 = {busy0, done0, rd_en0, ra1_0, ra2_0, st0, wr_en0, wa1_0, wa2_0, bi0, bn0};
   assign o1 = {busy1, done1, rd_en1, ra1_1, ra2_1, st1, wr_en1, wa1_1, wa2_1, bi1, bn1};

   int     nchk = 0;
   int     nerr = 0;
   longint cyc = 0;
   longint log_base = -100000;

   // Model: a pass is a list of 1024 issues, with a WB_LAT-cycle gap after each
   // 128th one; writes replay the issue stream WB_LAT cycles later.
   bit     m_busy  [NDUT];
   int     m_idx   [NDUT];
   int     m_gap   [NDUT];
   longint m_tdone [NDUT];
   tup_t   m_hist  [NDUT][4];
   obs_t   lg      [NDUT][LOGN];

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic tup_t issue_of(input int idx);
      int s, j, n, h, i, g;
      tup_t t;
      s = idx / 128; j = idx % 128;
      n = 256 >> s; h = n / 2; i = j % h; g = j / h;
      t.en = 1'b1;
      t.a1 = 8'(g * n + i);
      t.a2 = 8'(g * n + n - 1 - i);
      t.bi = 7'(i);
      t.bn = 9'(n);
      return t;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < NDUT; d++) begin
         m_busy[d] = 1'b0; m_idx[d] = 0; m_gap[d] = 0; m_tdone[d] = FAR;
         for (int i = 0; i < 4; i++) m_hist[d][i] = '0;
      end
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      nchk++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      for (int d = 0; d < NDUT; d++) begin
         obs_t o;
         o = (d == 0) ? o0 : o1;
         nchk++;
         if (o !== '0) begin
            nerr++;
            $display("FAIL %s dut%0d: outputs %h, expected all zero", nm, d, o);
         end
      end
   endtask

   task automatic check_cycle(input bit st, input bit hd);
      for (int d = 0; d < NDUT; d++) begin
         obs_t o;
         tup_t cur, ewr;
         bit   erd, ebusy, edone, bb, bad;
         int   L;
         longint k;
         L = lat_of(d);
         o = (d == 0) ? o0 : o1;
         erd   = m_busy[d] && m_idx[d] < 1024 && m_gap[d] == 0 && !hd;
         cur   = erd ? issue_of(m_idx[d]) : '0;
         edone = m_busy[d] && cyc == m_tdone[d];
         ebusy = m_busy[d] && cyc < m_tdone[d];
         ewr   = m_hist[d][L-1];
         bad = (o.busy !== ebusy) || (o.done !== edone) || (o.rd_en !== erd) || (o.wr !== ewr);
         if (erd && (o.ra1 !== cur.a1 || o.ra2 !== cur.a2 || o.stage !== 3'(m_idx[d] / 128)))
            bad = 1'b1;
         nchk++;
         if (bad) begin
            nerr++;
            $display("FAIL cycle %0d dut%0d (WB_LAT=%0d): got busy=%b done=%b rd_en=%b rd=%0d/%0d stage=%0d wr=%h, expected busy=%b done=%b rd_en=%b rd=%0d/%0d stage=%0d wr=%h",
                     cyc, d, L, o.busy, o.done, o.rd_en, o.ra1, o.ra2, o.stage, o.wr,
                     ebusy, edone, erd, cur.a1, cur.a2, m_idx[d] / 128, ewr);
         end
         k = cyc - log_base;
         if (k >= 0 && k < LOGN) lg[d][k] = o;
         // advance the model across the coming clock edge
         bb = m_busy[d];
         if (erd) begin
            if (m_idx[d] == 0) m_tdone[d] = cyc + 1024 + 8 * L;
            m_idx[d]++;
            if (m_idx[d] % 128 == 0 && m_idx[d] < 1024) m_gap[d] = L;
         end else if (m_busy[d] && m_idx[d] < 1024 && m_gap[d] > 0) begin
            m_gap[d]--;
         end else if (m_busy[d] && m_idx[d] < 1024 && hd && m_idx[d] > 0) begin
            m_tdone[d]++;
         end
         if (edone) m_busy[d] = 1'b0;
         if (!bb && st) begin
            m_busy[d] = 1'b1; m_idx[d] = 0; m_gap[d] = 0; m_tdone[d] = FAR;
         end
         for (int i = 3; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
         m_hist[d][0] = cur;
      end
   endtask

   task automatic step(input bit st, input bit hd);
      start = st;
      hold  = hd;
      #1;
      check_cycle(st, hd & HOLD_ON);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      hold  = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1; start = 1'b0; hold = 1'b0;
      #1;
      chk_zero(nm);
      model_reset();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_to_idle(input string nm);
      for (int n = 0; n < 1400 && (m_busy[0] || m_busy[1]); n++) step(1'b0, 1'b0);
      chk({nm, " dut0 idle"}, int'(o0.busy), 0);
      chk({nm, " dut1 idle"}, int'(o1.busy), 0);
   endtask

   vec_t vt [$];

   initial begin
      vt = '{
         '{0,    0, 1,   0, 255, 0, 0, 1, 0, 0, 0,   0, 0},
         '{0,    1, 1,   1, 254, 0, 0, 1, 1, 0, 255, 256, 0},
         '{0,    2, 1,   2, 253, 0, 0, 1, 1, 1, 254, 256, 1},
         '{0,  127, 1, 127, 128, 0, 0, 0, 0, 0, 0,   0, 0},
         '{0,  128, 0,   0,   0, 0, 0, 1, 1, 127, 128, 256, 127},
         '{0,  129, 1,   0, 127, 1, 0, 1, 0, 0, 0,   0, 0},
         '{0,  130, 1,   1, 126, 1, 0, 1, 1, 0, 127, 128, 0},
         '{0,  193, 1, 128, 255, 1, 0, 0, 0, 0, 0,   0, 0},
         '{0,  903, 1,   0,   1, 7, 0, 0, 0, 0, 0,   0, 0},
         '{0, 1030, 1, 254, 255, 7, 0, 0, 0, 0, 0,   0, 0},
         '{0, 1031, 0,   0,   0, 0, 0, 1, 1, 254, 255, 2, 0},
         '{0, 1032, 0,   0,   0, 0, 1, 1, 0, 0, 0,   0, 0},
         '{1,    2, 1,   2, 253, 0, 0, 1, 0, 0, 0,   0, 0},
         '{1,    3, 1,   3, 252, 0, 0, 1, 1, 0, 255, 256, 0},
         '{1,  130, 0,   0,   0, 0, 0, 1, 1, 127, 128, 256, 127},
         '{1,  131, 1,   0, 127, 1, 0, 0, 0, 0, 0,   0, 0},
         '{1, 1044, 1, 254, 255, 7, 0, 0, 0, 0, 0,   0, 0},
         '{1, 1047, 0,   0,   0, 0, 0, 1, 1, 254, 255, 2, 0},
         '{1, 1048, 0,   0,   0, 0, 1, 1, 0, 0, 0,   0, 0}
      };

      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("power-on reset");
      rst = 1'b0;
      repeat (2) step(1'b0, 1'b0);

      // Clean pass; a second start mid-pass must be ignored
      step(1'b1, 1'b0);
      log_base = cyc;
      for (int n = 0; n < 1400 && (m_busy[0] || m_busy[1]); n++) step(n == 300, 1'b0);
      chk("clean dut0 idle", int'(o0.busy), 0);
      chk("clean dut1 idle", int'(o1.busy), 0);
      foreach (vt[n]) begin
         obs_t o;
         o = lg[vt[n].d][vt[n].k];
         chk($sformatf("vec%0d rd_en", n), int'(o.rd_en), int'(vt[n].rd));
         chk($sformatf("vec%0d done", n), int'(o.done), int'(vt[n].done));
         if (vt[n].rd) begin
            chk($sformatf("vec%0d rd_addr1", n), int'(o.ra1), vt[n].a1);
            chk($sformatf("vec%0d rd_addr2", n), int'(o.ra2), vt[n].a2);
            chk($sformatf("vec%0d stage", n), int'(o.stage), vt[n].st);
         end
         if (vt[n].wchk) begin
            chk($sformatf("vec%0d wr_en", n), int'(o.wr.en), int'(vt[n].wen));
            chk($sformatf("vec%0d wr_addr1", n), int'(o.wr.a1), vt[n].wa1);
            chk($sformatf("vec%0d wr_addr2", n), int'(o.wr.a2), vt[n].wa2);
            chk($sformatf("vec%0d bf_n", n), int'(o.wr.bn), vt[n].wbn);
            chk($sformatf("vec%0d bf_i", n), int'(o.wr.bi), vt[n].wbi);
         end
      end

`ifdef BFLY_SCHED_HOLD_EN
      // Hold for 5 cycles at stage 2, j=10 of the WB_LAT=1 scheduler
      step(1'b1, 1'b0);
      log_base = cyc;
      for (int n = 0; n < 268; n++) step(1'b0, 1'b0);
      for (int n = 0; n < 5; n++) step(1'b0, 1'b1);
      run_to_idle("hold pass");
      chk("hold last issue addr1", int'(lg[0][267].ra1), 9);
      for (int n = 268; n < 273; n++) chk($sformatf("hold rd_en k%0d", n), int'(lg[0][n].rd_en), 0);
      chk("hold pending write", int'(lg[0][268].wr.en), 1);
      chk("hold pending wr_addr1", int'(lg[0][268].wr.a1), 9);
      chk("hold resume addr1", int'(lg[0][273].ra1), 10);
      chk("hold resume addr2", int'(lg[0][273].ra2), 53);
      chk("hold done not early", int'(lg[0][1036].done), 0);
      chk("hold done delayed", int'(lg[0][1037].done), 1);
`endif

      // Reset mid-pass at stage 4, then restart
      step(1'b1, 1'b0);
      log_base = cyc;
      for (int n = 0; n < 521; n++) step(1'b0, 1'b0);
      chk("pre-reset stage", int'(lg[0][520].stage), 4);
      do_reset("mid-pass reset");
      step(1'b1, 1'b0);
      log_base = cyc;
      repeat (3) step(1'b0, 1'b0);
      chk("restart rd_en", int'(lg[0][0].rd_en), 1);
      chk("restart addr1", int'(lg[0][0].ra1), 0);
      chk("restart addr2", int'(lg[0][0].ra2), 255);
      chk("restart stage", int'(lg[0][0].stage), 0);

      // Random starts, holds and occasional resets against the model
      log_base = -100000;
      for (int n = 0; n < 5000; n++) begin
         if ($urandom_range(0, 2499) == 0) do_reset("random reset");
         else step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
      end
      run_to_idle("final");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire
